// File: rtl/sar_search_if.sv
// sar_search_if - bundle for the successive-approximation search controller.
//
// Groups the start/done handshake, the search outputs and the comparator
// flags that come back from the external magnitude comparator.
//   start     : request a search (sampled only while idle)
//   eq/agtb/altb : comparator flags for a == / > / < guess
//   guess     : trial value driven to comparator b input
//   busy      : search in progress
//   done      : one-cycle pulse, result valid
//   result    : final value, held until the next search completes
//   flag_err  : an invalid flag combination was seen during the last search
//
// Modports:
//   slave  - the search controller
//   master - whoever issues start and closes the loop through the comparator
interface sar_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             eq;
  logic             agtb;
  logic             altb;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_err;

  modport slave (
    input  start, eq, agtb, altb,
    output guess, busy, done, result, flag_err
  );

  modport master (
    output start, eq, agtb, altb,
    input  guess, busy, done, result, flag_err
  );
endinterface

// File: rtl/sar_search.sv
// sar_search - successive-approximation search controller.
//
// Finds an unknown WIDTH-bit value by walking a trial value (guess) from the
// MSB down, one bit per clock, using the eq/agtb/altb flags of an external
// combinational comparator whose a input holds the unknown value.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   sif    : sar_search_if.slave (start, eq, agtb, altb, guess, busy, done,
//            result, flag_err)
//
// Build option:
//   SAR_EARLY_EXIT_EN - when defined, a valid eq flag ends the search at once
//                       with result = current guess. Undefined: every search
//                       takes exactly WIDTH compare cycles.
//
// state  | meaning
// IDLE   | waiting for start, guess = 0
// SEARCH | one bit decided per clock, bit index counts WIDTH-1 down to 0
// DONE   | one cycle, done pulse, result just updated
module sar_search #(
  parameter int WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  sar_search_if.slave sif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_err_q, flag_err_d;

  logic             flags_valid;
  logic             keep_bit;
  logic             early_exit;
  logic             last_bit;
  logic [WIDTH-1:0] acc_upd;

  // Anything other than exactly one flag is a comparator fault; it is
  // recorded and the bit is dropped as if altb had been seen.
  assign flags_valid = $onehot({sif.eq, sif.agtb, sif.altb});
  assign keep_bit    = flags_valid & (sif.eq | sif.agtb);
  assign last_bit    = (idx_q == '0);

`ifdef SAR_EARLY_EXIT_EN
  assign early_exit = sif.eq & ~sif.agtb & ~sif.altb;
`else
  assign early_exit = 1'b0;
`endif

  // Bits below idx are still zero in acc, so on a valid eq acc_upd already
  // equals the current guess; early exit can reuse the same result path.
  always_comb begin
    acc_upd         = acc_q;
    acc_upd[idx_q]  = keep_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      flag_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      flag_err_q <= flag_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    result_d   = result_q;
    flag_err_d = flag_err_q;
    unique case (state_q)
      IDLE: begin
        if (sif.start) begin
          state_d    = SEARCH;
          idx_d      = IW'(WIDTH - 1);
          acc_d      = '0;
          flag_err_d = 1'b0;
        end
      end
      SEARCH: begin
        acc_d = acc_upd;
        if (!flags_valid) flag_err_d = 1'b1;
        if (last_bit || early_exit) begin
          state_d  = DONE;
          result_d = acc_upd;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sif.guess    = '0;
    sif.busy     = 1'b0;
    sif.done     = 1'b0;
    sif.result   = result_q;
    sif.flag_err = flag_err_q;
    unique case (state_q)
      SEARCH: begin
        sif.guess = acc_q | (WIDTH'(1) << idx_q);
        sif.busy  = 1'b1;
      end
      DONE: begin
        sif.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  localparam int WIDTH = 8;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst_n;

  sar_search_if #(.WIDTH(WIDTH)) sif ();

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Comparator: a = target, b = guess. A single compare can be overridden.
  logic [WIDTH-1:0] target;
  int               force_k;
  logic [2:0]       force_flags;   // {eq, agtb, altb}
  int               cur_cmp;

  always_comb begin
    if (cur_cmp != 0 && cur_cmp == force_k) begin
      {sif.eq, sif.agtb, sif.altb} = force_flags;
    end else begin
      sif.eq   = (target == sif.guess);
      sif.agtb = (target >  sif.guess);
      sif.altb = (target <  sif.guess);
    end
  end

  int n_cmp;
  int n_mis;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: binary search over integers, one trial per bit weight.
  logic [WIDTH-1:0] exp_guess [WIDTH+1];
  int               exp_ncmp;
  logic [WIDTH-1:0] exp_res;
  logic             exp_err;

  function automatic void ref_search(input int a, input int fk, input logic [2:0] ff);
    int acc_m;
    int trial;
    logic [2:0] fl;
    acc_m    = 0;
    exp_ncmp = 0;
    exp_err  = 1'b0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      trial = acc_m + (1 << b);
      exp_guess[exp_ncmp] = trial[WIDTH-1:0];
      exp_ncmp++;
      if (exp_ncmp == fk) fl = ff;
      else fl = {a == trial, a > trial, a < trial};
      if ($countones(fl) != 1) begin
        exp_err = 1'b1;
      end else if (!fl[0]) begin
        acc_m = trial;
        if (EARLY && fl[2]) break;
      end
    end
    exp_res = acc_m[WIDTH-1:0];
  endfunction

  // Results of the last search run by do_search.
  logic [WIDTH-1:0] got_guess [WIDTH+1];
  int               r_ncmp;
  logic             r_done, r_busy, r_err, r_done2, r_err2;
  logic [WIDTH-1:0] r_res, r_guess, r_res2;

  task automatic do_search(input logic [WIDTH-1:0] a, input int fk, input logic [2:0] ff);
    target      = a;
    force_k     = fk;
    force_flags = ff;
    cur_cmp     = 0;
    @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    r_ncmp = 0;
    while (sif.busy && r_ncmp < WIDTH + 1) begin
      got_guess[r_ncmp] = sif.guess;
      cur_cmp = r_ncmp + 1;
      @(posedge clk); #1;
      r_ncmp++;
    end
    cur_cmp = 0;
    r_done  = sif.done;
    r_busy  = sif.busy;
    r_err   = sif.flag_err;
    r_res   = sif.result;
    r_guess = sif.guess;
    @(posedge clk); #1;
    r_done2 = sif.done;
    r_err2  = sif.flag_err;
    r_res2  = sif.result;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a;
    int               fk;
    logic [2:0]       ff;
    logic [WIDTH-1:0] res;
    logic             err;
    int               n_off;
    int               n_on;
  } vec_t;

  vec_t vecs [9];

  logic [WIDTH-1:0] a5_seq [WIDTH];

  int prev_busy, n_acc, last_acc, exp_int, exp_acc, guard;
  logic [WIDTH-1:0] ra;
  int rfk;
  logic [2:0] rff;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    target = '0;
    force_k = 0;
    force_flags = 3'b000;
    cur_cmp = 0;
    sif.start = 1'b0;

    //            a      fk  ff      res    err  off on
    vecs[0] = '{8'hA5, 0, 3'b000, 8'hA5, 1'b0, 8, 8};
    vecs[1] = '{8'h80, 0, 3'b000, 8'h80, 1'b0, 8, 1};
    vecs[2] = '{8'h00, 0, 3'b000, 8'h00, 1'b0, 8, 8};
    vecs[3] = '{8'hFF, 0, 3'b000, 8'hFF, 1'b0, 8, 8};
    vecs[4] = '{8'hA5, 3, 3'b110, 8'h9F, 1'b1, 8, 8};
    vecs[5] = '{8'h40, 0, 3'b000, 8'h40, 1'b0, 8, 2};
    vecs[6] = '{8'hA5, 5, 3'b000, 8'hA5, 1'b1, 8, 8};
    vecs[7] = '{8'h10, 0, 3'b000, 8'h10, 1'b0, 8, 4};
    vecs[8] = '{8'h01, 0, 3'b000, 8'h01, 1'b0, 8, 8};

    a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_guess", sif.guess, 0);
    check("rst_busy", sif.busy, 0);
    check("rst_done", sif.done, 0);
    check("rst_result", sif.result, 0);
    check("rst_flag_err", sif.flag_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // A5 walk: exact guess sequence and handshake timing
    do_search(8'hA5, 0, 3'b000);
    check("a5_ncmp", r_ncmp, WIDTH);
    for (int i = 0; i < WIDTH; i++) check($sformatf("a5_guess%0d", i), got_guess[i], a5_seq[i]);
    check("a5_done", r_done, 1);
    check("a5_busy_at_done", r_busy, 0);
    check("a5_guess_at_done", r_guess, 0);
    check("a5_result", r_res, 8'hA5);
    check("a5_flag_err", r_err, 0);
    check("a5_done_drop", r_done2, 0);
    check("a5_result_held", r_res2, 8'hA5);

    // Table vectors
    for (int v = 0; v < 9; v++) begin
      do_search(vecs[v].a, vecs[v].fk, vecs[v].ff);
      check($sformatf("vec%0d_ncmp", v), r_ncmp, EARLY ? vecs[v].n_on : vecs[v].n_off);
      check($sformatf("vec%0d_done", v), r_done, 1);
      check($sformatf("vec%0d_result", v), r_res, vecs[v].res);
      check($sformatf("vec%0d_flag_err", v), r_err, vecs[v].err);
      check($sformatf("vec%0d_err_held", v), r_err2, vecs[v].err);
      check($sformatf("vec%0d_done_drop", v), r_done2, 0);
    end

    // Randomized searches against the reference model
    for (int t = 0; t < 60; t++) begin
      ra  = WIDTH'($urandom);
      rfk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
      rff = 3'($urandom_range(0, 7));
      ref_search(int'(ra), rfk, rff);
      do_search(ra, rfk, rff);
      check($sformatf("rnd%0d_ncmp", t), r_ncmp, exp_ncmp);
      check($sformatf("rnd%0d_result", t), r_res, exp_res);
      check($sformatf("rnd%0d_flag_err", t), r_err, exp_err);
      check($sformatf("rnd%0d_done", t), r_done, 1);
      if (r_ncmp == exp_ncmp)
        for (int i = 0; i < exp_ncmp; i++)
          check($sformatf("rnd%0d_guess%0d", t, i), got_guess[i], exp_guess[i]);
    end

    // Asynchronous reset in the middle of the 4th compare
    target  = 8'hA5;
    force_k = 0;
    @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_guess", sif.guess, 0);
    check("midrst_busy", sif.busy, 0);
    check("midrst_done", sif.done, 0);
    check("midrst_result", sif.result, 0);
    check("midrst_flag_err", sif.flag_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_search(8'hA5, 0, 3'b000);
    check("postrst_ncmp", r_ncmp, WIDTH);
    check("postrst_result", r_res, 8'hA5);
    check("postrst_done", r_done, 1);

    // start held high: back-to-back searches
    target  = 8'h3C;
    force_k = 0;
    ref_search(8'h3C, 0, 3'b000);
    exp_int = exp_ncmp + 2;
    exp_acc = (4 * (WIDTH + 2) + exp_int - 1) / exp_int;
    prev_busy = 0;
    n_acc = 0;
    last_acc = -1;
    @(negedge clk);
    sif.start = 1'b1;
    for (int c = 0; c < 4 * (WIDTH + 2); c++) begin
      @(posedge clk); #1;
      if (sif.busy && prev_busy == 0) begin
        if (last_acc >= 0) check("b2b_interval", c - last_acc, exp_int);
        last_acc = c;
        n_acc++;
      end
      if (sif.done) check("b2b_result", sif.result, 8'h3C);
      prev_busy = int'(sif.busy);
    end
    sif.start = 1'b0;
    check("b2b_accepts", n_acc, exp_acc);
    repeat (WIDTH + 3) @(posedge clk);

    // start pulse during busy is ignored
    target = 8'h5A;
    @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    guard = 0;
    while (!sif.done && guard < 2 * WIDTH) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ignore_done_seen", sif.done, 1);
    check("ignore_result", sif.result, 8'h5A);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignore_no_restart", sif.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
